// File: rtl/tristate_bus_pkg.sv
// Shared types and sizing helpers for the tri-state bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Sized for the largest supported configuration so every instance shares them.
  localparam int MAX_CHANNELS   = 16;
  localparam int PTR_W          = $clog2(MAX_CHANNELS);
  localparam int MAX_TURNAROUND = 7;
  localparam int TURN_W         = $clog2(MAX_TURNAROUND + 1);

  // Tenure counter must reach MAX_HOLD; keep at least one bit when unlimited.
  function automatic int hold_cnt_w(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

  function automatic int onehot_idx(input logic [MAX_CHANNELS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

  // Distance from the round-robin base to a channel, scanning upward with wrap.
  function automatic int rr_dist(input int ch, input int base, input int n);
    int d;
    d = ch - base;
    if (d < 0) d = d + n;
    return d;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Handshake/bus bundle between data sources and the tri-state bus arbiter.
// Latency: n/a (wires only).
// Backpressure: none; REQ is level-sensitive and GNT is the only answer.
//   LD   load strobes, one per source     D    packed source data, slice i = source i
//   REQ  ownership requests, one per src  GNT  one-hot grant (or zero)
//   BUSY bus owned or in turnaround
interface tristate_bus_arbiter_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       LD;
  logic [CHANNELS*WIDTH-1:0] D;
  logic [CHANNELS-1:0]       REQ;
  logic [CHANNELS-1:0]       GNT;
  logic                      BUSY;

  modport master (output LD, output D, output REQ, input GNT, input BUSY);
  modport slave  (input LD, input D, input REQ, output GNT, output BUSY);
endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin winner select: first requester at or after ptr, wrapping at CHANNELS-1.
// Latency: combinational.
// Backpressure: none.
//   req     request vector           ptr     highest-priority channel
//   winner  one-hot winner (or zero) any_req at least one request present
module rr_priority_picker
  import tristate_bus_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [CHANNELS-1:0] winner,
  output logic                any_req
);

  logic found;

  // Outer loop walks priority rank, inner loop finds the channel at that rank;
  // all indices are loop constants so the result is a plain mux tree.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && req[i] && (rr_dist(i, int'(ptr), CHANNELS) == k)) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/tristate_bus_arbiter.sv
// CHANNELS holding registers share one tri-state bus Y under round-robin ownership,
// with TURNAROUND dead cycles between owners and tenure capped at MAX_HOLD.
// Latency: REQ->GNT 1 cycle; LD->Y 1 cycle; Y is combinational from GNT/holding regs.
// Backpressure: none; a requester simply waits (REQ held) until granted.
//   CLK, CLR_N  clock and synchronous active-low reset
//   bus         LD/D/REQ in, GNT/BUSY out
//   Y           shared bus, owner's holding register or Z
// Optional BUS_KEEPER_EN: Y holds the last driven value instead of Z when unowned.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                 CLK,
  input  logic                 CLR_N,
  tristate_bus_arbiter_if.slave bus,
  // Kept as a direct port so the tri-state net resolves at the board/bus level.
  output wire  [WIDTH-1:0]     Y
);

  localparam int HOLD_W = hold_cnt_w(MAX_HOLD);
  localparam logic [TURN_W-1:0] TURN_LOAD =
    TURN_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] gnt_q, gnt_d;
  logic [CHANNELS-1:0] winner;
  logic                any_req;
  logic [PTR_W-1:0]    ptr_q, ptr_d, next_ptr;
  logic [HOLD_W-1:0]   ten_q, ten_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic [WIDTH-1:0]    hold_q [CHANNELS];
  logic [WIDTH-1:0]    drive_val;
  logic                drive_en;
  logic                rearb;
  logic                release_bus;
  logic                owner_req;
  logic                other_req;
  int                  win_idx;

  // Holding registers load independently of who owns the bus.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      for (int i = 0; i < CHANNELS; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.LD[i]) hold_q[i] <= bus.D[i*WIDTH +: WIDTH];
      end
    end
  end

  rr_priority_picker #(.CHANNELS(CHANNELS)) u_picker (
    .req     (bus.REQ),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    win_idx  = onehot_idx(MAX_CHANNELS'(winner));
    next_ptr = (win_idx + 1 >= CHANNELS) ? '0 : PTR_W'(win_idx + 1);
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      ten_q   <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      ten_q   <= ten_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    ten_d       = ten_q;
    turn_d      = turn_q;
    rearb       = 1'b0;
    release_bus = 1'b0;
    owner_req   = |(bus.REQ & gnt_q);
    other_req   = |(bus.REQ & ~gnt_q);

    case (state_q)
      IDLE: rearb = 1'b1;

      DRIVE: begin
        // ten_q counts cycles already held, so ten_q+1 includes the current one:
        // an owner keeps the bus for at most MAX_HOLD cycles under contention.
        release_bus = !owner_req ||
                      ((MAX_HOLD > 0) && (int'(ten_q) + 1 >= MAX_HOLD) && other_req);
        if (release_bus) begin
          if (TURNAROUND > 0) begin
            state_d = TURN;
            gnt_d   = '0;
            turn_d  = TURN_LOAD;
          end else begin
            rearb = 1'b1;
          end
        end else if (int'(ten_q) < MAX_HOLD) begin
          ten_d = ten_q + 1'b1;
        end
      end

      TURN: begin
        if (turn_q == '0) rearb = 1'b1;
        else              turn_d = turn_q - 1'b1;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    // Pointer already sits one past the last owner, so a re-requesting owner
    // ranks lowest without any extra masking.
    if (rearb) begin
      if (any_req) begin
        state_d = DRIVE;
        gnt_d   = winner;
        ptr_d   = next_ptr;
        ten_d   = '0;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  // GNT is one-hot or zero, so OR-ing the selected registers never mixes sources.
  always_comb begin
    drive_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_q[i]) drive_val = drive_val | hold_q[i];
    end
  end

  assign drive_en = |gnt_q;
  assign bus.GNT  = gnt_q;
  assign bus.BUSY = drive_en || (state_q == TURN);

`ifdef BUS_KEEPER_EN
  logic [WIDTH-1:0] keep_q;

  always_ff @(posedge CLK) begin
    if (!CLR_N)        keep_q <= '0;
    else if (drive_en) keep_q <= drive_val;
  end

  assign Y = drive_en ? drive_val : keep_q;
`else
  assign Y = drive_en ? drive_val : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: two instances (TURNAROUND=1/MAX_HOLD=2 and
// TURNAROUND=0/MAX_HOLD=16) driven cycle by cycle; expected GNT/BUSY/Y per cycle
// go into a scoreboard queue and are popped and compared after each edge.
module tb_tristate_bus_arbiter;

  logic CLK   = 1'b0;
  logic CLR_N = 1'b0;
  wire [7:0] y_a;
  wire [7:0] y_b;

  tristate_bus_arbiter_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
  tristate_bus_arbiter_if #(.WIDTH(8), .CHANNELS(4)) bus_b ();

  tristate_bus_arbiter #(.WIDTH(8), .CHANNELS(4), .TURNAROUND(1), .MAX_HOLD(2)) dut_a (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .bus   (bus_a),
    .Y     (y_a)
  );

  tristate_bus_arbiter #(.WIDTH(8), .CHANNELS(4), .TURNAROUND(0), .MAX_HOLD(16)) dut_b (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .bus   (bus_b),
    .Y     (y_b)
  );

  wire yz_a = (y_a === 8'bzzzzzzzz);
  wire yz_b = (y_b === 8'bzzzzzzzz);

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    bit         dut;
    logic [3:0] gnt;
    logic       busy;
    bit         drv;
    logic [7:0] y;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] keep_a   = 8'h00;
  logic [7:0] keep_b   = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Queue the expectation for the next edge, advance one cycle, then pop and compare.
  task automatic step(input bit dut, input string tag, input logic [3:0] gnt,
                      input logic busy, input bit drv, input logic [7:0] y);
    exp_t       e;
    logic [3:0] g_obs;
    logic       b_obs;
    logic [7:0] y_obs;
    logic       z_obs;
    e.tag  = tag;
    e.dut  = dut;
    e.gnt  = gnt;
    e.busy = busy;
    e.drv  = drv;
    if (drv) begin
      e.y = y;
      if (dut) keep_b = y;
      else     keep_a = y;
    end else begin
      e.y = dut ? keep_b : keep_a;
    end
    sb.push_back(e);

    @(posedge CLK);
    #1;
    e     = sb.pop_front();
    g_obs = e.dut ? bus_b.GNT  : bus_a.GNT;
    b_obs = e.dut ? bus_b.BUSY : bus_a.BUSY;
    y_obs = e.dut ? y_b : y_a;
    z_obs = e.dut ? yz_b : yz_a;
    check({e.tag, ".gnt"},  32'(g_obs), 32'(e.gnt));
    check({e.tag, ".busy"}, 32'(b_obs), 32'(e.busy));
    if (e.drv) begin
      check({e.tag, ".y"}, 32'(y_obs), 32'(e.y));
    end else begin
`ifdef BUS_KEEPER_EN
      check({e.tag, ".ykeep"}, 32'(y_obs), 32'(e.y));
`else
      check({e.tag, ".yz"}, 32'(z_obs), 32'd1);
`endif
    end
  endtask

  initial begin
    bus_a.LD = '0; bus_a.D = '0; bus_a.REQ = '0;
    bus_b.LD = '0; bus_b.D = '0; bus_b.REQ = '0;

    // Reset with all requests asserted, then first grant goes to channel 0.
    CLR_N = 1'b0; bus_a.REQ = 4'hF; keep_a = 8'h00; keep_b = 8'h00;
    step(0, "rst0", 4'b0000, 1'b0, 0, 8'h00);
    step(0, "rst1", 4'b0000, 1'b0, 0, 8'h00);
    CLR_N = 1'b1;
    step(0, "rst_rel", 4'b0001, 1'b1, 1, 8'h00);
    bus_a.REQ = 4'h0;
    step(0, "rst_drop", 4'b0000, 1'b1, 0, 8'h00);
    step(0, "rst_idle", 4'b0000, 1'b0, 0, 8'h00);

    // Load and drive channel 2, reload while owning, then change D without LD.
    bus_a.LD = 4'b0100; bus_a.D = 32'h00A5_0000; bus_a.REQ = 4'b0100;
    step(0, "ld_a5", 4'b0100, 1'b1, 1, 8'hA5);
    bus_a.D = 32'h003C_0000;
    step(0, "ld_3c", 4'b0100, 1'b1, 1, 8'h3C);
    bus_a.LD = 4'b0000; bus_a.D = 32'h00FF_0000;
    step(0, "ld_hold", 4'b0100, 1'b1, 1, 8'h3C);
    bus_a.REQ = 4'h0;
    step(0, "ld_rel", 4'b0000, 1'b1, 0, 8'h00);
    step(0, "ld_idle", 4'b0000, 1'b0, 0, 8'h00);

    // Round robin under full contention, tenure capped at 2 cycles, 1 Z cycle between.
    CLR_N = 1'b0; keep_a = 8'h00; keep_b = 8'h00;
    step(0, "rst2", 4'b0000, 1'b0, 0, 8'h00);
    CLR_N = 1'b1;
    bus_a.LD = 4'hF; bus_a.D = 32'h4433_2211;
    step(0, "rr_load", 4'b0000, 1'b0, 0, 8'h00);
    bus_a.LD = 4'h0; bus_a.REQ = 4'hF;
    for (int k = 0; k < 4; k++) begin
      step(0, $sformatf("rr%0d_a", k), 4'(1 << k), 1'b1, 1, 8'(8'h11 * (k + 1)));
      step(0, $sformatf("rr%0d_b", k), 4'(1 << k), 1'b1, 1, 8'(8'h11 * (k + 1)));
      step(0, $sformatf("rr%0d_turn", k), 4'b0000, 1'b1, 0, 8'h00);
    end
    step(0, "rr_wrap", 4'b0001, 1'b1, 1, 8'h11);
    bus_a.REQ = 4'h0;
    step(0, "rr_rel", 4'b0000, 1'b1, 0, 8'h00);
    step(0, "rr_idle", 4'b0000, 1'b0, 0, 8'h00);

    // Reset while channel 3 drives: regs cleared and priority restarts at channel 0.
    bus_a.REQ = 4'b1000;
    step(0, "mr_g3", 4'b1000, 1'b1, 1, 8'h44);
    CLR_N = 1'b0; keep_a = 8'h00; keep_b = 8'h00; bus_a.REQ = 4'b1001;
    step(0, "mr_rst", 4'b0000, 1'b0, 0, 8'h00);
    CLR_N = 1'b1;
    step(0, "mr_g0", 4'b0001, 1'b1, 1, 8'h00);
    step(0, "mr_g0b", 4'b0001, 1'b1, 1, 8'h00);
    step(0, "mr_turn", 4'b0000, 1'b1, 0, 8'h00);
    step(0, "mr_g3z", 4'b1000, 1'b1, 1, 8'h00);
    bus_a.REQ = 4'h0;
    step(0, "mr_rel", 4'b0000, 1'b1, 0, 8'h00);
    step(0, "mr_idle", 4'b0000, 1'b0, 0, 8'h00);

    // Owner drives 5A then releases: Z (or kept 5A) through TURN and IDLE.
    bus_a.LD = 4'b0010; bus_a.D = 32'h0000_5A00; bus_a.REQ = 4'b0010;
    step(0, "kp_drv", 4'b0010, 1'b1, 1, 8'h5A);
    bus_a.LD = 4'h0; bus_a.REQ = 4'h0;
    step(0, "kp_turn", 4'b0000, 1'b1, 0, 8'h00);
    step(0, "kp_idle", 4'b0000, 1'b0, 0, 8'h00);
    step(0, "kp_idle2", 4'b0000, 1'b0, 0, 8'h00);

    // Zero turnaround: handover on the same edge with no Z gap.
    bus_b.LD = 4'b0011; bus_b.D = 32'h0000_C1C0; bus_b.REQ = 4'b0001;
    step(1, "t0_g0", 4'b0001, 1'b1, 1, 8'hC0);
    bus_b.LD = 4'h0; bus_b.REQ = 4'b0011;
    step(1, "t0_hold", 4'b0001, 1'b1, 1, 8'hC0);
    bus_b.REQ = 4'b0010;
    step(1, "t0_swap", 4'b0010, 1'b1, 1, 8'hC1);
    bus_b.REQ = 4'h0;
    step(1, "t0_idle", 4'b0000, 1'b0, 0, 8'h00);
    bus_b.REQ = 4'b0001;
    step(1, "t0_g0b", 4'b0001, 1'b1, 1, 8'hC0);
    bus_b.REQ = 4'b0100;
    step(1, "t0_simul", 4'b0100, 1'b1, 1, 8'h00);
    bus_b.REQ = 4'h0;
    step(1, "t0_end", 4'b0000, 1'b0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
